// File: rtl/safety_bist_pkg.sv
// safety_bist_pkg: register map, bit positions and master FSM states for the BIST APB master
package safety_bist_pkg;
  localparam logic [31:0] BIST_CTRL_OFF   = 32'h0;
  localparam logic [31:0] BIST_STATUS_OFF = 32'h4;
  localparam logic [31:0] BIST_SIG_OFF    = 32'h8;
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_FAIL_BIT  = 2;
  typedef enum logic [2:0] {
    S_IDLE, S_WR_START, S_GAP, S_RD_STATUS, S_RD_SIG, S_FINISH, S_ABORT
  } bist_mst_state_e;
endpackage

// File: rtl/safety_apb_xfer.sv
// safety_apb_xfer: single APB transfer engine with SETUP/ACCESS handshake and pready timeout
module safety_apb_xfer #(
  parameter int PREADY_TMO = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic        tmo_o,
  output logic [31:0] rdata_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i
);
  logic        r_psel, r_penable, r_pwrite, r_done, r_tmo;
  logic [31:0] r_paddr, r_pwdata, r_rdata;
  logic [15:0] r_wait;
  assign psel_o    = r_psel;
  assign penable_o = r_penable;
  assign pwrite_o  = r_pwrite;
  assign paddr_o   = r_paddr;
  assign pwdata_o  = r_pwdata;
  assign done_o    = r_done;
  assign tmo_o     = r_tmo;
  assign rdata_o   = r_rdata;
  // Request is held by the master for a whole state, so a new transfer is refused in the completion cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_rdata   <= '0;
      r_done    <= 1'b0;
      r_tmo     <= 1'b0;
      r_wait    <= '0;
    end else begin
      r_done <= 1'b0;
      r_tmo  <= 1'b0;
      if (!r_psel) begin
        if (req_i && !r_done && !r_tmo) begin
          r_psel   <= 1'b1;
          r_pwrite <= write_i;
          r_paddr  <= addr_i;
          r_pwdata <= wdata_i;
        end
      end else if (!r_penable) begin
        r_penable <= 1'b1;
        r_wait    <= '0;
      end else if (pready_i) begin
        r_psel    <= 1'b0;
        r_penable <= 1'b0;
        r_done    <= 1'b1;
        r_rdata   <= prdata_i;
      end else if (r_wait == 16'(PREADY_TMO - 1)) begin
        r_psel    <= 1'b0;
        r_penable <= 1'b0;
        r_tmo     <= 1'b1;
      end else begin
        r_wait <= r_wait + 16'd1;
      end
    end
  end
endmodule

// File: rtl/safety_bist_apb_master.sv
// safety_bist_apb_master: periodic BIST scheduler driving the execute block's BIST slave over APB
module safety_bist_apb_master import safety_bist_pkg::*; #(
  parameter int          INTERVAL   = 1000,
  parameter int          POLL_GAP   = 8,
  parameter int          MAX_POLLS  = 64,
  parameter int          PREADY_TMO = 16,
  parameter logic [31:0] GOLDEN_SIG = 32'hA5C3_0F1E
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        core_sleep_i,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  output logic        bist_pass_o,
  output logic        bist_fail_o,
  output logic        timeout_o,
  output logic [31:0] signature_o,
  output logic [15:0] run_count_o,
  input  logic        clr_i
);
  bist_mst_state_e r_state;
  logic [31:0] r_icnt, r_sig;
  logic [15:0] r_poll, r_gap, r_runs;
  logic        r_exit, r_stat_fail, r_run_tmo, r_pass, r_fail, r_tmo;
  logic        w_req, w_write, w_done, w_tmo, w_exit, w_pass_ok;
  logic [31:0] w_addr, w_wdata, w_rdata;
  assign bist_pass_o = r_pass;
  assign bist_fail_o = r_fail;
  assign timeout_o   = r_tmo;
  assign signature_o = r_sig;
  assign run_count_o = r_runs;
  // Transfer request decoded from the current state
  always_comb begin
    w_req     = r_state inside {S_WR_START, S_RD_STATUS, S_RD_SIG, S_ABORT};
    w_write   = r_state == S_WR_START || r_state == S_ABORT;
    w_addr    = r_state == S_RD_STATUS ? BIST_STATUS_OFF : r_state == S_RD_SIG ? BIST_SIG_OFF : BIST_CTRL_OFF;
    w_wdata   = 32'd1 << (r_state == S_ABORT ? CTRL_ABORT_BIT : CTRL_START_BIT);
    w_exit    = r_exit || !core_sleep_i;
    w_pass_ok = !r_stat_fail && !r_run_tmo && r_sig == GOLDEN_SIG;
  end
  safety_apb_xfer #(.PREADY_TMO(PREADY_TMO)) u_xfer (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(w_req), .write_i(w_write), .addr_i(w_addr), .wdata_i(w_wdata),
    .done_o(w_done), .tmo_o(w_tmo), .rdata_o(w_rdata),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i)
  );
  // Run scheduler; a sleep exit seen during a transfer is remembered and acted on once it completes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_icnt      <= 32'(INTERVAL);
      r_poll      <= '0;
      r_gap       <= '0;
      r_runs      <= '0;
      r_sig       <= '0;
      r_exit      <= 1'b0;
      r_stat_fail <= 1'b0;
      r_run_tmo   <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_tmo       <= 1'b0;
    end else begin
      r_pass <= 1'b0;
      r_fail <= (r_state == S_FINISH && !w_pass_ok) || (r_fail && !clr_i);
      r_tmo  <= (r_state == S_FINISH && r_run_tmo) || (r_tmo && !clr_i);
      if (!core_sleep_i && r_state inside {S_WR_START, S_RD_STATUS, S_RD_SIG}) r_exit <= 1'b1;
      case (r_state)
        S_IDLE:
          if (!(enable_i && core_sleep_i)) r_icnt <= 32'(INTERVAL);
          else if (r_icnt != '0) r_icnt <= r_icnt - 32'd1;
          else begin
            r_state     <= S_WR_START;
            r_exit      <= 1'b0;
            r_stat_fail <= 1'b0;
            r_run_tmo   <= 1'b0;
          end
        S_WR_START:
          if (w_done) begin
            r_state <= w_exit ? S_ABORT : S_GAP;
            r_poll  <= '0;
            r_gap   <= '0;
          end
        S_GAP:
          if (!core_sleep_i) r_state <= S_ABORT;
          else if (r_gap == 16'(POLL_GAP - 1)) r_state <= S_RD_STATUS;
          else r_gap <= r_gap + 16'd1;
        S_RD_STATUS:
          if (w_done) begin
            r_poll <= r_poll + 16'd1;
            r_gap  <= '0;
            if (w_exit) r_state <= S_ABORT;
            else if (w_rdata[STAT_DONE_BIT]) begin
              r_stat_fail <= w_rdata[STAT_FAIL_BIT];
              r_state     <= S_RD_SIG;
            end else if (r_poll + 16'd1 == 16'(MAX_POLLS)) begin
              r_run_tmo <= 1'b1;
              r_state   <= S_FINISH;
            end else r_state <= S_GAP;
          end
        S_RD_SIG:
          if (w_done) begin
            r_sig   <= w_exit ? r_sig : w_rdata;
            r_state <= w_exit ? S_ABORT : S_FINISH;
          end
        S_FINISH: begin
          r_pass  <= w_pass_ok;
          r_runs  <= r_runs + {15'd0, r_runs != 16'hFFFF};
          r_icnt  <= 32'(INTERVAL);
          r_state <= S_IDLE;
        end
        S_ABORT:
          if (w_done || w_tmo) begin
            r_icnt  <= 32'(INTERVAL);
            r_state <= S_IDLE;
          end
        default: r_state <= S_IDLE;
      endcase
      if (w_tmo && r_state != S_ABORT) begin
        r_run_tmo <= 1'b1;
        r_state   <= S_FINISH;
      end
    end
  end
endmodule

// File: tb/tb_safety_bist_apb_master.sv
// tb_safety_bist_apb_master: directed scenarios against a small behavioural BIST slave
module tb_safety_bist_apb_master;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, sleep = 1'b0, clr = 1'b0;
  logic psel, penable, pwrite, pready, pass, fail, tmo, sdone;
  logic [31:0] paddr, pwdata, prdata, sig;
  logic [15:0] runs;
  logic [31:0] sigval = 32'hA5C3_0F1E;
  logic        fail_bit = 1'b0;
  logic [64:0] cap = '0;
  int checks = 0, failures = 0;
  int wait_n = 0, done_at = 3, acc = 0, len = 0, run_min = 0, run_max = 0;
  int run_status = 0, run_sig = 0, n_start = 0, n_abort = 0, n_pass = 0, unstable = 0;
  int k;
  always #5 clk = ~clk;
  safety_bist_apb_master #(.INTERVAL(10), .POLL_GAP(2), .MAX_POLLS(4), .PREADY_TMO(16)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .core_sleep_i(sleep),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .pwdata_o(pwdata),
    .prdata_i(prdata), .pready_i(pready),
    .bist_pass_o(pass), .bist_fail_o(fail), .timeout_o(tmo), .signature_o(sig),
    .run_count_o(runs), .clr_i(clr)
  );
  assign sdone  = done_at != 0 && run_status + 1 >= done_at;
  assign pready = psel && penable && acc >= wait_n;
  assign prdata = paddr == 32'h4 ? {29'd0, fail_bit, sdone, !sdone} : paddr == 32'h8 ? sigval : 32'd0;
  always @(posedge clk) begin
    if (pass) n_pass <= n_pass + 1;
    if (psel && !penable) begin
      acc <= 0;
      len <= 1;
      cap <= {pwrite, paddr, pwdata};
    end
    if (psel && penable) begin
      acc <= acc + 1;
      len <= len + 1;
      if ({pwrite, paddr, pwdata} !== cap) unstable <= unstable + 1;
    end
    if (psel && penable && pready) begin
      if (pwrite && paddr == 32'h0 && pwdata == 32'h1) begin
        n_start    <= n_start + 1;
        run_status <= 0;
        run_sig    <= 0;
        run_min    <= len + 1;
        run_max    <= len + 1;
      end else begin
        run_min <= (len + 1 < run_min) ? len + 1 : run_min;
        run_max <= (len + 1 > run_max) ? len + 1 : run_max;
        if (pwrite && paddr == 32'h0 && pwdata == 32'h2) n_abort <= n_abort + 1;
        if (!pwrite && paddr == 32'h4) run_status <= run_status + 1;
        if (!pwrite && paddr == 32'h8) run_sig <= run_sig + 1;
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_runs(input logic [15:0] t);
    int w = 0;
    while (runs !== t && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("run_wait", {16'd0, runs}, {16'd0, t});
  endtask
  initial begin
    cyc(3);
    check("rst_psel", 32'(psel), 0);
    check("rst_penable", 32'(penable), 0);
    check("rst_pwrite", 32'(pwrite), 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_tmo", 32'(tmo), 0);
    check("rst_sig", sig, 0);
    check("rst_runs", {16'd0, runs}, 0);
    rst = 1'b0;
    enable = 1'b1;
    sleep = 1'b1;
    wait_runs(16'd1);
    enable = 1'b0;
    cyc(3);
    check("pass_starts", n_start, 1);
    check("pass_status_reads", run_status, 3);
    check("pass_sig_reads", run_sig, 1);
    check("pass_pulses", n_pass, 1);
    check("pass_fail", 32'(fail), 0);
    check("pass_tmo", 32'(tmo), 0);
    check("pass_sig", sig, 32'hA5C3_0F1E);
    check("pass_min_len", run_min, 2);
    check("pass_max_len", run_max, 2);
    sigval = 32'h0000_0001;
    enable = 1'b1;
    wait_runs(16'd2);
    enable = 1'b0;
    cyc(3);
    check("mis_fail", 32'(fail), 1);
    check("mis_sig", sig, 32'h1);
    check("mis_pulses", n_pass, 1);
    check("mis_tmo", 32'(tmo), 0);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    check("mis_clr_fail", 32'(fail), 0);
    sigval = 32'hA5C3_0F1E;
    done_at = 0;
    enable = 1'b1;
    wait_runs(16'd3);
    enable = 1'b0;
    cyc(3);
    check("poll_status_reads", run_status, 4);
    check("poll_sig_reads", run_sig, 0);
    check("poll_tmo", 32'(tmo), 1);
    check("poll_fail", 32'(fail), 1);
    check("poll_pulses", n_pass, 1);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    check("poll_clr_tmo", 32'(tmo), 0);
    check("poll_clr_fail", 32'(fail), 0);
    done_at = 3;
    wait_n = 3;
    enable = 1'b1;
    wait_runs(16'd4);
    enable = 1'b0;
    cyc(3);
    check("ws_min_len", run_min, 5);
    check("ws_max_len", run_max, 5);
    check("ws_unstable", unstable, 0);
    check("ws_pulses", n_pass, 2);
    check("ws_fail", 32'(fail), 0);
    check("ws_status_reads", run_status, 3);
    wait_n = 2;
    enable = 1'b1;
    k = 0;
    while (!(psel && penable && !pwrite && paddr == 32'h4) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("exit_found_status", 32'(k < 200), 1);
    sleep = 1'b0;
    k = 0;
    while (n_abort != 1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("exit_abort_writes", n_abort, 1);
    cyc(5);
    check("exit_psel", 32'(psel), 0);
    check("exit_runs", {16'd0, runs}, 4);
    check("exit_pulses", n_pass, 2);
    check("exit_fail", 32'(fail), 0);
    check("exit_tmo", 32'(tmo), 0);
    check("exit_status_reads", run_status, 1);
    cyc(30);
    check("exit_no_restart", n_start, 5);
    wait_n = 1000;
    sleep = 1'b1;
    wait_runs(16'd5);
    check("stuck_tmo", 32'(tmo), 1);
    check("stuck_fail", 32'(fail), 1);
    check("stuck_psel", 32'(psel), 0);
    check("stuck_access_cycles", acc, 16);
    check("stuck_no_abort", n_abort, 1);
    k = 0;
    while (!psel && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("stuck_restart_gap", k, 12);
    check("stuck_restart_addr", paddr, 0);
    check("stuck_restart_wdata", pwdata, 1);
    cyc(3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_psel", 32'(psel), 0);
    check("rst_mid_penable", 32'(penable), 0);
    rst = 1'b0;
    sleep = 1'b0;
    cyc(20);
    check("rst_mid_no_abort", n_abort, 1);
    check("rst_mid_runs", {16'd0, runs}, 0);
    check("rst_mid_tmo", 32'(tmo), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
